// File: rtl/gbsha_pkg.sv
// gbsha_pkg: shared types and constants for the PRBS7 symbol checker.
//   gbsha_state_e : checker FSM state (SEEK / VERIFY / LOCKED), 2-bit encoding
//                   that is also exported on the checker's state port.
//   PRBS_LEN      : PRBS7 history length (x^7 + x^6 + 1).
//   TAP_A / TAP_B : history taps feeding the next bit (h6 ^ h5).
//   SYM_W         : bits per received symbol.
package gbsha_pkg;

    typedef enum logic [1:0] {
        SEEK   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } gbsha_state_e;

    localparam int PRBS_LEN = 7;
    localparam int TAP_A    = 6;
    localparam int TAP_B    = 5;
    localparam int SYM_W    = 2;

endpackage

// File: rtl/gbsha_prbs7_step.sv
// gbsha_prbs7_step: combinational one-symbol advance of the local PRBS7 LFSR.
// Ports:
//   h        in  [PRBS_LEN-1:0]  history, h[0] newest bit, h[6] oldest
//   pred_sym out [SYM_W-1:0]     predicted symbol {p1, p0}, p1 is the earlier bit
//   h_adv    out [PRBS_LEN-1:0]  history after both predicted bits are shifted in
module gbsha_prbs7_step
    import gbsha_pkg::*;
(
    input  logic [PRBS_LEN-1:0] h,
    output logic [SYM_W-1:0]    pred_sym,
    output logic [PRBS_LEN-1:0] h_adv
);

    logic                p1;
    logic                p0;
    logic [PRBS_LEN-1:0] h_mid;

    // p0 is predicted from the history after p1 has already been shifted in.
    assign p1       = h[TAP_A] ^ h[TAP_B];
    assign h_mid    = {h[PRBS_LEN-2:0], p1};
    assign p0       = h_mid[TAP_A] ^ h_mid[TAP_B];
    assign h_adv    = {h_mid[PRBS_LEN-2:0], p0};
    assign pred_sym = {p1, p0};

endmodule

// File: rtl/gbsha_prbs_checker.sv
// gbsha_prbs_checker: self-synchronising PRBS7 checker for the 2-bit symbol
// stream leaving the FIR filter. SEEK loads the history from received bits,
// VERIFY requires LOCK_CNT clean symbols from the free-running local LFSR,
// LOCKED counts bit errors and falls back to SEEK after LOSS_THR consecutive
// errored symbols.
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   sym_valid in   sym_in valid this cycle
//   sym_in    in   [1:0] received symbol, bit1 earlier PRBS bit
//   err_clr   in   synchronous clear of err_cnt (wins over an increment)
//   locked    out  high while in LOCKED
//   state     out  [1:0] 0 SEEK, 1 VERIFY, 2 LOCKED
//   err_cnt   out  [ERR_W-1:0] saturating bit-error count (LOCKED only)
//   err_pulse out  one-cycle strobe for an errored symbol checked in LOCKED
module gbsha_prbs_checker
    import gbsha_pkg::*;
#(
    parameter int LOCK_CNT = 16,
    parameter int LOSS_THR = 4,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sym_valid,
    input  logic [1:0]       sym_in,
    input  logic             err_clr,
    output logic             locked,
    output logic [1:0]       state,
    output logic [ERR_W-1:0] err_cnt,
    output logic             err_pulse
);

    localparam int VC_W = $clog2(LOCK_CNT + 1);
    localparam int CC_W = $clog2(LOSS_THR + 1);

    gbsha_state_e        state_reg, state_next;
    logic [PRBS_LEN-1:0] h_reg, h_next;
    logic [1:0]          fill_reg, fill_next;
    logic [VC_W-1:0]     vcnt_reg, vcnt_next;
    logic [CC_W-1:0]     ccnt_reg, ccnt_next;
    logic [ERR_W-1:0]    err_cnt_reg, err_cnt_next;
    logic                err_pulse_reg, err_pulse_next;
    logic                locked_reg, locked_next;

    logic [SYM_W-1:0]    pred_sym;
    logic [PRBS_LEN-1:0] h_adv;
    logic [SYM_W-1:0]    bit_err;
    logic [1:0]          sym_errs;
    logic [ERR_W:0]      err_sum;

    gbsha_prbs7_step u_step (
        .h        (h_reg),
        .pred_sym (pred_sym),
        .h_adv    (h_adv)
    );

    genvar gi;
    generate
        for (gi = 0; gi < SYM_W; gi++) begin : g_cmp
            assign bit_err[gi] = sym_in[gi] ^ pred_sym[gi];
        end
    endgenerate

    assign sym_errs = {1'b0, bit_err[1]} + {1'b0, bit_err[0]};
    // One extra bit catches the carry that signals saturation.
    assign err_sum  = {1'b0, err_cnt_reg} + {{(ERR_W-1){1'b0}}, sym_errs};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= SEEK;
            h_reg         <= '0;
            fill_reg      <= '0;
            vcnt_reg      <= '0;
            ccnt_reg      <= '0;
            err_cnt_reg   <= '0;
            err_pulse_reg <= 1'b0;
            locked_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            h_reg         <= h_next;
            fill_reg      <= fill_next;
            vcnt_reg      <= vcnt_next;
            ccnt_reg      <= ccnt_next;
            err_cnt_reg   <= err_cnt_next;
            err_pulse_reg <= err_pulse_next;
            locked_reg    <= locked_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next     = state_reg;
        h_next         = h_reg;
        fill_next      = fill_reg;
        vcnt_next      = vcnt_reg;
        ccnt_next      = ccnt_reg;
        err_cnt_next   = err_cnt_reg;
        err_pulse_next = 1'b0;

        if (sym_valid) begin
            case (state_reg)
                SEEK: begin
                    // Load received bits; four symbols cover all seven taps.
                    h_next = {h_reg[PRBS_LEN-3:0], sym_in};
                    if (fill_reg == 2'd3) begin
                        state_next = VERIFY;
                        fill_next  = '0;
                        vcnt_next  = '0;
                    end else begin
                        fill_next = fill_reg + 2'd1;
                    end
                end
                VERIFY: begin
                    h_next = h_adv;
                    if (sym_errs == 2'd0) begin
                        vcnt_next = vcnt_reg + VC_W'(1);
                        if (vcnt_reg == VC_W'(LOCK_CNT - 1)) begin
                            state_next = LOCKED;
                            ccnt_next  = '0;
                        end
                    end else begin
                        state_next = SEEK;
                        fill_next  = '0;
                    end
                end
                LOCKED: begin
                    h_next = h_adv;
                    if (sym_errs != 2'd0) begin
                        err_pulse_next = 1'b1;
                        err_cnt_next   = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
                        if (ccnt_reg == CC_W'(LOSS_THR - 1)) begin
                            state_next = SEEK;
                            fill_next  = '0;
                            ccnt_next  = '0;
                        end else begin
                            ccnt_next = ccnt_reg + CC_W'(1);
                        end
                    end else begin
                        ccnt_next = '0;
                    end
                end
                default: begin
                    state_next = SEEK;
                    fill_next  = '0;
                end
            endcase
        end

        if (err_clr) begin
            err_cnt_next = '0;
        end

        locked_next = (state_next == LOCKED);
    end

    // Outputs are straight register taps
    always_comb begin
        state     = state_reg;
        locked    = locked_reg;
        err_cnt   = err_cnt_reg;
        err_pulse = err_pulse_reg;
    end

endmodule

// File: tb/tb_gbsha_prbs_checker.sv
// Testbench for gbsha_prbs_checker. Two instances (ERR_W=16 and ERR_W=4) see
// the same stimulus; a queue-based PRBS7 model predicts every output and a
// negedge process compares both instances each cycle, while the directed
// sequence adds hand-computed literal expectations.
module tb_gbsha_prbs_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sym_valid;
    logic [1:0]  sym_in;
    logic        err_clr;

    logic        a_locked, b_locked;
    logic [1:0]  a_state, b_state;
    logic [15:0] a_err;
    logic [3:0]  b_err;
    logic        a_pulse, b_pulse;

    always #5 clk = ~clk;

    gbsha_prbs_checker #(.LOCK_CNT(16), .LOSS_THR(4), .ERR_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid), .sym_in(sym_in),
        .err_clr(err_clr), .locked(a_locked), .state(a_state),
        .err_cnt(a_err), .err_pulse(a_pulse)
    );

    gbsha_prbs_checker #(.LOCK_CNT(16), .LOSS_THR(4), .ERR_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid), .sym_in(sym_in),
        .err_clr(err_clr), .locked(b_locked), .state(b_state),
        .err_cnt(b_err), .err_pulse(b_pulse)
    );

    int n_err = 0;
    int n_chk = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The expected bit sequence is kept as a plain list; the next bit is
    // b[n] = b[n-7] ^ b[n-6] taken straight from the list.
    bit mq[$];
    int m_mode, m_fill, m_vcnt, m_ccnt, m_err16, m_err4, m_pulse;

    task automatic model_reset();
        mq.delete();
        m_mode = 0; m_fill = 0; m_vcnt = 0; m_ccnt = 0;
        m_err16 = 0; m_err4 = 0; m_pulse = 0;
    endtask

    task automatic model_step(input bit v, input logic [1:0] s, input bit clr);
        bit p1, p0;
        int e;
        m_pulse = 0;
        if (v) begin
            if (m_mode == 0) begin
                mq.push_back(s[1]);
                mq.push_back(s[0]);
                m_fill++;
                if (m_fill == 4) begin
                    m_mode = 1; m_vcnt = 0; m_fill = 0;
                end
            end else begin
                p1 = mq[mq.size()-7] ^ mq[mq.size()-6];
                mq.push_back(p1);
                p0 = mq[mq.size()-7] ^ mq[mq.size()-6];
                mq.push_back(p0);
                e = int'(s[1] ^ p1) + int'(s[0] ^ p0);
                if (m_mode == 1) begin
                    if (e == 0) begin
                        m_vcnt++;
                        if (m_vcnt == 16) begin
                            m_mode = 2; m_ccnt = 0;
                        end
                    end else begin
                        m_mode = 0; m_fill = 0;
                    end
                end else begin
                    if (e > 0) begin
                        m_pulse = 1;
                        m_err16 = (m_err16 + e > 65535) ? 65535 : m_err16 + e;
                        m_err4  = (m_err4 + e > 15) ? 15 : m_err4 + e;
                        m_ccnt++;
                        if (m_ccnt == 4) begin
                            m_mode = 0; m_fill = 0; m_ccnt = 0;
                        end
                    end else begin
                        m_ccnt = 0;
                    end
                end
            end
            while (mq.size() > 32) void'(mq.pop_front());
        end
        if (clr) begin
            m_err16 = 0; m_err4 = 0;
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("a_state",  int'(a_state),  m_mode);
            chk("a_locked", int'(a_locked), int'(m_mode == 2));
            chk("a_pulse",  int'(a_pulse),  m_pulse);
            chk("a_errcnt", int'(a_err),    m_err16);
            chk("b_state",  int'(b_state),  m_mode);
            chk("b_locked", int'(b_locked), int'(m_mode == 2));
            chk("b_pulse",  int'(b_pulse),  m_pulse);
            chk("b_errcnt", int'(b_err),    m_err4);
        end
    end

    // ---------------- stimulus ----------------
    logic [6:0] tx_h;

    task automatic gen_sym(output logic [1:0] s);
        logic b1, b0;
        b1   = tx_h[6] ^ tx_h[5];
        tx_h = {tx_h[5:0], b1};
        b0   = tx_h[6] ^ tx_h[5];
        tx_h = {tx_h[5:0], b0};
        s    = {b1, b0};
    endtask

    // Drive one cycle; returns 1 time unit after the sampling edge.
    task automatic send(input bit v, input logic [1:0] s, input bit clr);
        @(negedge clk);
        #1;
        sym_valid = v;
        sym_in    = s;
        err_clr   = clr;
        @(posedge clk);
        model_step(v, s, clr);
        #1;
    endtask

    task automatic send_gen(input logic [1:0] flip, input bit clr);
        logic [1:0] s;
        gen_sym(s);
        send(1'b1, s ^ flip, clr);
    endtask

    task automatic relock_check(input string tag);
        for (int i = 1; i <= 20; i++) begin
            send_gen(2'b00, 1'b0);
            if (i == 4)  chk({tag, "_verify"}, int'(a_state), 1);
            if (i == 19) chk({tag, "_not_yet"}, int'(a_locked), 0);
            if (i == 20) chk({tag, "_relock"}, int'(a_locked), 1);
        end
    endtask

    initial begin
        logic [1:0] s;
        int gexp[4];
        int vcount;
        gexp = '{0, 0, 0, 2};

        rst_n = 1'b0; sym_valid = 1'b0; sym_in = 2'b00; err_clr = 1'b0;
        tx_h = 7'h7F;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state",  int'(a_state),  0);
        chk("rst_locked", int'(a_locked), 0);
        chk("rst_err",    int'(a_err),    0);
        chk("rst_pulse",  int'(a_pulse),  0);
        @(negedge clk);
        #1;
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // 1: clean stream from seed 7F
        for (int i = 1; i <= 1000; i++) begin
            gen_sym(s);
            if (i <= 4) chk("gen_sym", int'(s), gexp[i-1]);
            send(1'b1, s, 1'b0);
            if (i == 3)  chk("t1_seek3", int'(a_state), 0);
            if (i == 4)  chk("t1_verify4", int'(a_state), 1);
            if (i == 19) chk("t1_unlocked19", int'(a_locked), 0);
            if (i == 20) chk("t1_locked20", int'(a_locked), 1);
        end
        chk("t1_err0", int'(a_err), 0);

        // 2: single-bit then double-bit error while locked
        send_gen(2'b10, 1'b0);
        chk("t2_pulse1", int'(a_pulse), 1);
        chk("t2_err1", int'(a_err), 1);
        send_gen(2'b00, 1'b0);
        chk("t2_pulse1_off", int'(a_pulse), 0);
        repeat (5) send_gen(2'b00, 1'b0);
        send_gen(2'b11, 1'b0);
        chk("t2_pulse2", int'(a_pulse), 1);
        chk("t2_err3", int'(a_err), 3);
        send_gen(2'b00, 1'b0);
        chk("t2_pulse2_off", int'(a_pulse), 0);
        chk("t2_locked", int'(a_locked), 1);

        // 3: four inverted symbols drop lock
        for (int k = 1; k <= 4; k++) begin
            send_gen(2'b11, 1'b0);
            if (k == 3) chk("t3_still_locked", int'(a_locked), 1);
        end
        chk("t3_state_seek", int'(a_state), 0);
        chk("t3_unlocked", int'(a_locked), 0);
        chk("t3_err11", int'(a_err), 11);
        relock_check("t3");
        chk("t3_err_hold", int'(a_err), 11);

        // 4: saturation on the 4-bit counter, clear precedence
        send_gen(2'b00, 1'b1);
        chk("t4_clr", int'(b_err), 0);
        for (int k = 0; k < 10; k++) begin
            send_gen(2'b11, 1'b0);
            send_gen(2'b00, 1'b0);
        end
        chk("t4_sat15", int'(b_err), 15);
        chk("t4_wide20", int'(a_err), 20);
        send_gen(2'b11, 1'b1);
        chk("t4_clr_wins_a", int'(a_err), 0);
        chk("t4_clr_wins_b", int'(b_err), 0);
        send_gen(2'b01, 1'b0);
        chk("t4_err1", int'(a_err), 1);
        send(1'b0, 2'b11, 1'b1);
        chk("t4_clr_idle", int'(a_err), 0);
        chk("t4_idle_locked", int'(a_state), 2);

        // 5: async reset mid-cycle, then gapped stream
        repeat (3) send_gen(2'b00, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_locked", int'(a_locked), 0);
        chk("t5_async_state", int'(a_state), 0);
        chk("t5_async_err", int'(b_err), 0);
        model_reset();
        sym_valid = 1'b0;
        err_clr   = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        vcount = 0;
        for (int i = 0; i < 200 && vcount < 20; i++) begin
            if (i % 3 == 2 || i % 7 == 5) begin
                send(1'b0, 2'($urandom_range(0, 3)), 1'b0);
            end else begin
                send_gen(2'b00, 1'b0);
                vcount++;
                if (vcount == 19) chk("t5_not_yet", int'(a_locked), 0);
                if (vcount == 20) chk("t5_locked", int'(a_locked), 1);
            end
        end
        chk("t5_valid_count", vcount, 20);
        chk("t5_err0", int'(a_err), 0);

        // 6: error during VERIFY at verify count 10
        rst_n = 1'b0;
        model_reset();
        sym_valid = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (14) send_gen(2'b00, 1'b0);
        chk("t6_verify", int'(a_state), 1);
        send_gen(2'b01, 1'b0);
        chk("t6_back_seek", int'(a_state), 0);
        chk("t6_err0", int'(a_err), 0);
        relock_check("t6");
        chk("t6_err_end", int'(a_err), 0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
